// File: rtl/writeback_unit.sv
// Writeback arbiter: merges ALU results with a small FIFO of load responses
// into a single register-file write port, with load formatting and an anti-starvation limit.
module writeback_unit #(
   parameter int XLEN         = 32,
   parameter int LQ_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [4:0]                alu_rd,
   input  logic [XLEN-1:0]           alu_result,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [4:0]                load_rd,
   input  logic [2:0]                load_funct3,
   input  logic [1:0]                load_offset,
   input  logic [XLEN-1:0]           load_rdata,
   output logic                      rd_wen,
   output logic [4:0]                rd_addr,
   output logic [XLEN-1:0]           rd_wdata,
   output logic                      load_err,
   output logic [$clog2(LQ_DEPTH):0] lq_count
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } load_kind_t;

   typedef struct packed {
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [1:0]      offset;
      logic [XLEN-1:0] rdata;
   } lq_entry_t;

   lq_entry_t       lq_mem [LQ_DEPTH];
   lq_entry_t       head;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [SW-1:0]   starve_cnt;
   logic            lq_empty;
   logic            enq;
   logic            alu_gnt;
   logic            load_gnt;
   logic            load_legal;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_value;

   // Ready signals depend only on registered state, so an entry enqueued
   // this cycle cannot be seen by the grant logic until the next one.
   assign lq_empty   = (lq_count == '0);
   assign load_ready = (lq_count < CW'(LQ_DEPTH));
   assign alu_ready  = !(!lq_empty && (starve_cnt == SW'(STARVE_LIMIT)));
   assign enq        = load_valid && load_ready;
   assign alu_gnt    = alu_valid && alu_ready;
   assign load_gnt   = !alu_gnt && !lq_empty;
   assign head       = lq_mem[rd_ptr];

   always_comb begin
      byte_sel = head.rdata[7:0];
      case (head.offset)
         2'd0:    byte_sel = head.rdata[7:0];
         2'd1:    byte_sel = head.rdata[15:8];
         2'd2:    byte_sel = head.rdata[23:16];
         default: byte_sel = head.rdata[31:24];
      endcase
      half_sel = head.offset[1] ? head.rdata[31:16] : head.rdata[15:0];
   end

   always_comb begin
      load_legal = 1'b0;
      load_value = '0;
      case (head.funct3)
         LD_LB: begin
            load_legal = 1'b1;
            load_value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         end
         LD_LBU: begin
            load_legal = 1'b1;
            load_value = {{(XLEN-8){1'b0}}, byte_sel};
         end
         LD_LH: begin
            load_legal = !head.offset[0];
            load_value = {{(XLEN-16){half_sel[15]}}, half_sel};
         end
         LD_LHU: begin
            load_legal = !head.offset[0];
            load_value = {{(XLEN-16){1'b0}}, half_sel};
         end
         LD_LW: begin
            load_legal = (head.offset == 2'd0);
            load_value = head.rdata;
         end
         default: begin
            load_legal = 1'b0;
            load_value = '0;
         end
      endcase
   end

   // Queue storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (enq) begin
         lq_mem[wr_ptr] <= '{rd: load_rd, funct3: load_funct3,
                             offset: load_offset, rdata: load_rdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         lq_count   <= '0;
         starve_cnt <= '0;
         rd_wen     <= 1'b0;
         rd_addr    <= '0;
         rd_wdata   <= '0;
         load_err   <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (load_gnt) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({enq, load_gnt})
            2'b10:   lq_count <= lq_count + 1'b1;
            2'b01:   lq_count <= lq_count - 1'b1;
            default: lq_count <= lq_count;
         endcase

         if (lq_empty || load_gnt) begin
            starve_cnt <= '0;
         end else if (alu_gnt) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         rd_wen   <= 1'b0;
         load_err <= 1'b0;
         if (alu_gnt) begin
            if (alu_rd != 5'd0) begin
               rd_wen   <= 1'b1;
               rd_addr  <= alu_rd;
               rd_wdata <= alu_result;
            end
         end else if (load_gnt) begin
            if (!load_legal) begin
               load_err <= 1'b1;
            end else if (head.rd != 5'd0) begin
               rd_wen   <= 1'b1;
               rd_addr  <= head.rd;
               rd_wdata <= load_value;
            end
         end
      end
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, register and data width.
REQ-002 SHALL have parameter LQ_DEPTH, default 2, load-response queue entries (power of two, >=2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive ALU grants tolerated while a load waits.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port alu_valid  in  1  ALU result presented.
REQ-007 SHALL have port alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
REQ-008 SHALL have port alu_rd  in  5  ALU destination index.
REQ-009 SHALL have port alu_result  in  XLEN  ALU result.
REQ-010 SHALL have port load_valid  in  1  load response presented.
REQ-011 SHALL have port load_ready  out  1  queue can accept a load response.
REQ-012 SHALL have port load_rd  in  5  load destination index.
REQ-013 SHALL have port load_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-014 SHALL have port load_offset  in  2  byte offset of load address.
REQ-015 SHALL have port load_rdata  in  XLEN  raw aligned memory word.
REQ-016 SHALL have port rd_wen  out  1  register-file write enable.
REQ-017 SHALL have port rd_addr  out  5  register-file write index.
REQ-018 SHALL have port rd_wdata  out  XLEN  register-file write data.
REQ-019 SHALL have port load_err  out  1  one-cycle pulse: dropped load (illegal funct3 or misaligned).
REQ-020 SHALL have port lq_count  out  $clog2(LQ_DEPTH)+1  queued load entries.

Function
REQ-021 load_ready SHALL equal (lq_count < LQ_DEPTH), with no same-cycle dequeue credit.
REQ-022 load_valid && load_ready SHALL enqueue {rd, funct3, offset, rdata} at the edge; a queued entry SHALL NOT be granted in its enqueue cycle.
REQ-023 Queue SHALL be FIFO; pointers SHALL wrap modulo LQ_DEPTH; simultaneous enqueue and dequeue SHALL leave lq_count unchanged.
REQ-024 Grant per cycle: ALU if alu_valid && alu_ready; else queue head if lq_count != 0; else none.
REQ-025 alu_ready SHALL be 0 only when lq_count != 0 and starve_cnt == STARVE_LIMIT, else 1.
REQ-026 starve_cnt SHALL increment on each ALU grant while lq_count != 0, and clear on any load grant or when lq_count == 0.
REQ-027 rd_wen/rd_addr/rd_wdata SHALL be registered: grant in cycle N -> outputs valid in cycle N+1; no grant -> rd_wen=0 in N+1.
REQ-028 Load formatting: byte = rdata[8*offset +: 8], half = rdata[16*offset[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
REQ-029 LH/LHU with offset[0]=1, LW with offset!=0, or funct3 outside REQ-013 SHALL dequeue the entry with rd_wen=0 and load_err=1 in cycle N+1.
REQ-030 Any granted write with rd index 0 SHALL produce rd_wen=0 and SHALL still consume the source (no error).
REQ-031 rd_addr/rd_wdata SHALL hold previous values when rd_wen=0.

Reset
REQ-032 While rst=1 at an edge: queue emptied, lq_count=0, starve_cnt=0, rd_wen=0, rd_addr=0, rd_wdata=0, load_err=0; in-flight entries discarded.
REQ-033 During rst=1, load_ready and alu_ready SHALL follow REQ-021/REQ-025 from reset state (both 1 after first reset edge).

Verification
REQ-034 ALU only: alu_valid=1, alu_rd=5, alu_result=0x1234 in cycle N -> rd_wen=1, rd_addr=5, rd_wdata=0x1234 in N+1.
REQ-035 LB offset 3, rdata=0x80FF_FF00, rd=7 -> two cycles later rd_wen=1, rd_addr=7, rd_wdata=0xFFFF_FF80; same with LBU -> 0x0000_0080.
REQ-036 Queue full: 2 loads accepted while alu_valid=1 continuously -> load_ready=0, lq_count=2; after 4 ALU grants alu_ready=0 for one cycle, one load written, starve_cnt=0.
REQ-037 LW offset 2, rd=9 -> rd_wen=0, load_err=1 one cycle, lq_count decrements; LH offset 1 likewise.
REQ-038 ALU write with alu_rd=0, result 0xDEAD_BEEF -> rd_wen=0, alu_ready=1, no error.
REQ-039 rst asserted with lq_count=2 and alu_valid=1 -> next cycle lq_count=0, rd_wen=0, load_ready=1, queued loads never written.
